// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_WAIT_FALL = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    id_width = (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle seen by the arbiter.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = UART_DATA_W
);
  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         tx_din;
  logic                      tx_trigger;
  logic                      tx_busy;
  logic [ID_W-1:0]           active_id;
  logic                      timeout_err;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_din, tx_trigger, active_id, timeout_err
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_din, tx_trigger, active_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after pointer.
module uart_tx_arbiter_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);

  int pos;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      pos = int'(pointer) + i;
      if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (pos == k && req[k]) begin
          grant_valid = 1'b1;
          grant_idx   = ID_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte producers,
// sequencing one frame at a time over the trigger/busy handshake.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = UART_DATA_W,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = 32'($clog2(BUSY_TIMEOUT + 1));

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               trig_q, trig_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               err_q, err_d;

  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;

  uart_tx_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req         (bus.req),
    .pointer     (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      din_q   <= '0;
      trig_q  <= 1'b0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      din_q   <= din_d;
      trig_q  <= trig_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  // Next state and next register values; ack/trigger are single-cycle pulses.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    din_d   = din_q;
    trig_d  = 1'b0;
    id_d    = id_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid && !bus.tx_busy) begin
          din_d   = bus.req_data[grant_idx*DATA_W +: DATA_W];
          id_d    = grant_idx;
          ack_d   = NUM_REQ'(1) << grant_idx;
          trig_d  = 1'b1;
          ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          cnt_d   = '0;
          state_d = ST_WAIT_RISE;
        end
      end
      ST_WAIT_RISE: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_FALL;
        end else begin
          if (cnt_q != CNT_W'(BUSY_TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= CNT_W'(BUSY_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_FALL: begin
        if (!bus.tx_busy) state_d = ST_GAP;
      end
      ST_GAP: begin
        // Lets the stop bit finish before the next trigger.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.tx_din      = din_q;
  assign bus.tx_trigger  = trig_q;
  assign bus.active_id   = id_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter paired with a small UART transmitter model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned BUSY_TIMEOUT = 16;
  localparam int unsigned BAUD_PERIOD  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // UART transmitter model: start bit, 8 data bits LSB first, stop bit.
  logic       m_busy;
  logic [9:0] m_shift;
  logic [2:0] m_baud;
  logic [3:0] m_nbits;
  logic       serial;
  logic       ovr_en;
  logic       ovr_val;

  assign bus.tx_busy = ovr_en ? ovr_val : m_busy;
  assign serial      = m_busy ? m_shift[0] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_shift <= '1;
      m_baud  <= '0;
      m_nbits <= '0;
    end else if (!m_busy) begin
      if (bus.tx_trigger && !ovr_en) begin
        m_busy  <= 1'b1;
        m_shift <= {1'b1, bus.tx_din, 1'b0};
        m_baud  <= '0;
        m_nbits <= '0;
      end
    end else if (m_baud == 3'(BAUD_PERIOD - 1)) begin
      m_baud  <= '0;
      m_shift <= {1'b1, m_shift[9:1]};
      m_nbits <= m_nbits + 4'd1;
      if (m_nbits == 4'd9) m_busy <= 1'b0;
    end else begin
      m_baud <= m_baud + 3'd1;
    end
  end

  int passed = 0;
  int total  = 0;
  int trig_cnt = 0;
  int ack_cnt  = 0;
  int bad_cnt  = 0;

  // Protocol monitor: one-hot ack, ack coincident with trigger, no trigger while busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_trigger) trig_cnt++;
      if (bus.ack != '0) ack_cnt++;
      if ($countones(bus.ack) > 1 || ((bus.ack != '0) != bus.tx_trigger) ||
          (bus.tx_trigger && bus.tx_busy))
        bad_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    ovr_en       = 1'b0;
    ovr_val      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (bus.ack != '0) begin
        for (int k = 0; k < int'(NUM_REQ); k++) if (bus.ack[k]) idx = k;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int c;
    tick();
    tick();
    c = 0;
    while (bus.tx_busy && c < 300) begin
      tick();
      c++;
    end
    if (bus.tx_busy) begin
      total++;
      $display("FAIL wait_idle: tx_busy=%0b after %0d cycles, required 0", bus.tx_busy, c);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack: got %b exp 0000", bus.ack); else passed++;
    total++; if (bus.tx_din !== 8'h00) $display("FAIL reset_din: got %h exp 00", bus.tx_din); else passed++;
    total++; if (bus.tx_trigger !== 1'b0) $display("FAIL reset_trig: got %b exp 0", bus.tx_trigger); else passed++;
    total++; if (bus.active_id !== 2'd0) $display("FAIL reset_id: got %0d exp 0", bus.active_id); else passed++;
    total++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_err: got %b exp 0", bus.timeout_err); else passed++;
  endtask

  task automatic test_single();
    int t0;
    logic [9:0] cap;
    t0 = trig_cnt;
    bus.req_data[2*DATA_W +: DATA_W] = 8'hA5;
    bus.req = 4'b0100;
    tick();
    total++; if (bus.ack !== 4'b0100) $display("FAIL single_ack: got %b exp 0100", bus.ack); else passed++;
    total++; if (bus.tx_trigger !== 1'b1) $display("FAIL single_trig: got %b exp 1", bus.tx_trigger); else passed++;
    total++; if (bus.tx_din !== 8'hA5) $display("FAIL single_din: got %h exp a5", bus.tx_din); else passed++;
    total++; if (bus.active_id !== 2'd2) $display("FAIL single_id: got %0d exp 2", bus.active_id); else passed++;
    bus.req = '0;
    tick();
    total++; if ({bus.ack, bus.tx_trigger} !== 5'b0) $display("FAIL single_pulse: ack=%b trig=%b exp 0000/0", bus.ack, bus.tx_trigger); else passed++;
    tick(); tick(); tick();
    cap[0] = serial;
    for (int k = 1; k < 10; k++) begin
      repeat (BAUD_PERIOD) tick();
      cap[k] = serial;
    end
    total++; if (cap !== 10'b1101001010) $display("FAIL single_serial: got %b exp 1101001010 (bit0 first from right)", cap); else passed++;
    wait_idle();
    total++; if (trig_cnt - t0 !== 1) $display("FAIL single_trig_count: got %0d exp 1", trig_cnt - t0); else passed++;
  endtask

  task automatic test_round_robin();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    logic [7:0] bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int idx, t0, b0;
    do_reset();
    t0 = trig_cnt;
    b0 = bad_cnt;
    for (int i = 0; i < 4; i++) bus.req_data[i*DATA_W +: DATA_W] = bytes[i];
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(200, idx);
      if (n == 4) bus.req = '0;
      total++; if (idx !== exp_idx[n]) $display("FAIL rr_order[%0d]: got %0d exp %0d", n, idx, exp_idx[n]); else passed++;
      total++; if (bus.tx_din !== bytes[exp_idx[n]]) $display("FAIL rr_din[%0d]: got %h exp %h", n, bus.tx_din, bytes[exp_idx[n]]); else passed++;
    end
    wait_idle();
    total++; if (trig_cnt - t0 !== 5) $display("FAIL rr_trig_count: got %0d exp 5", trig_cnt - t0); else passed++;
    total++; if (bad_cnt - b0 !== 0) $display("FAIL rr_protocol: got %0d violations exp 0", bad_cnt - b0); else passed++;
  endtask

  task automatic test_fairness();
    int idx, a0;
    do_reset();
    a0 = ack_cnt;
    bus.req_data[1*DATA_W +: DATA_W] = 8'h5A;
    bus.req_data[3*DATA_W +: DATA_W] = 8'hC3;
    bus.req = 4'b0010;
    wait_ack(200, idx);
    total++; if (idx !== 1) $display("FAIL fair_first: got %0d exp 1", idx); else passed++;
    repeat (10) tick();
    bus.req[3] = 1'b1;
    wait_ack(200, idx);
    bus.req[3] = 1'b0;
    total++; if (idx !== 3) $display("FAIL fair_second: got %0d exp 3", idx); else passed++;
    wait_ack(200, idx);
    bus.req[1] = 1'b0;
    total++; if (idx !== 1) $display("FAIL fair_third: got %0d exp 1", idx); else passed++;
    wait_idle();
    total++; if (ack_cnt - a0 !== 3) $display("FAIL fair_ack_count: got %0d exp 3", ack_cnt - a0); else passed++;
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    ovr_en  = 1'b1;
    ovr_val = 1'b0;
    bus.req_data[0 +: DATA_W] = 8'h5A;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    total++; if (bus.tx_trigger !== 1'b1) $display("FAIL to_trig: got %b exp 1", bus.tx_trigger); else passed++;
    cnt = 0;
    while (!bus.timeout_err && cnt < 40) begin
      tick();
      cnt++;
    end
    total++; if (cnt !== int'(BUSY_TIMEOUT)) $display("FAIL to_latency: got %0d exp %0d", cnt, BUSY_TIMEOUT); else passed++;
    bus.req_data[1*DATA_W +: DATA_W] = 8'h3C;
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    total++; if (bus.ack !== 4'b0010) $display("FAIL to_next_ack: got %b exp 0010", bus.ack); else passed++;
    total++; if (bus.tx_din !== 8'h3C) $display("FAIL to_next_din: got %h exp 3c", bus.tx_din); else passed++;
    repeat (20) tick();
    total++; if (bus.timeout_err !== 1'b1) $display("FAIL to_sticky: got %b exp 1", bus.timeout_err); else passed++;
    total++; if (bus.tx_trigger !== 1'b0) $display("FAIL to_idle_trig: got %b exp 0", bus.tx_trigger); else passed++;
    ovr_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int idx;
    do_reset();
    bus.req_data[1*DATA_W +: DATA_W] = 8'h81;
    bus.req = 4'b0010;
    wait_ack(200, idx);
    bus.req = '0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    total++; if (bus.ack !== 4'b0000) $display("FAIL mid_ack: got %b exp 0000", bus.ack); else passed++;
    total++; if (bus.tx_din !== 8'h00) $display("FAIL mid_din: got %h exp 00", bus.tx_din); else passed++;
    total++; if (bus.tx_trigger !== 1'b0) $display("FAIL mid_trig: got %b exp 0", bus.tx_trigger); else passed++;
    total++; if (bus.active_id !== 2'd0) $display("FAIL mid_id: got %0d exp 0", bus.active_id); else passed++;
    total++; if (bus.timeout_err !== 1'b0) $display("FAIL mid_err: got %b exp 0", bus.timeout_err); else passed++;
    rst = 1'b0;
    bus.req_data[0 +: DATA_W]        = 8'h42;
    bus.req_data[3*DATA_W +: DATA_W] = 8'h24;
    bus.req = 4'b1001;
    tick();
    bus.req = '0;
    total++; if (bus.ack !== 4'b0001) $display("FAIL mid_after_ack: got %b exp 0001", bus.ack); else passed++;
    total++; if (bus.tx_din !== 8'h42) $display("FAIL mid_after_din: got %h exp 42", bus.tx_din); else passed++;
    wait_idle();
  endtask

  task automatic test_external_busy();
    int a0, t0;
    do_reset();
    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    a0 = ack_cnt;
    t0 = trig_cnt;
    bus.req_data[0 +: DATA_W] = 8'h77;
    bus.req = 4'b0001;
    repeat (10) tick();
    total++; if (ack_cnt - a0 !== 0) $display("FAIL ext_no_ack: got %0d acks exp 0", ack_cnt - a0); else passed++;
    total++; if (trig_cnt - t0 !== 0) $display("FAIL ext_no_trig: got %0d triggers exp 0", trig_cnt - t0); else passed++;
    ovr_val = 1'b0;
    ovr_en  = 1'b0;
    tick();
    bus.req = '0;
    total++; if (bus.ack !== 4'b0001) $display("FAIL ext_ack: got %b exp 0001", bus.ack); else passed++;
    total++; if (bus.tx_trigger !== 1'b1) $display("FAIL ext_trig: got %b exp 1", bus.tx_trigger); else passed++;
    wait_idle();
    total++; if (bad_cnt !== 0) $display("FAIL protocol_total: got %0d violations exp 0", bad_cnt); else passed++;
  endtask

  initial begin
    ovr_en       = 1'b0;
    ovr_val      = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_reset_mid_frame();
    test_external_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
